pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central sequencing unit for the five-stage RV32I pipeline. It drives the enable and flush controls for PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects and data-memory wait states through a small FSM with a timeout, and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before fault (≥1)
- CNT_W, 32: stall counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination register of instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- ex_mem_memread, ex_mem_memwrite  in  1 each  MEM-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
- if_id_flush, id_ex_flush  out  1 each  load NOP/zero control into register
- mem_wb_bubble  out  1  MEM/WB captures zero CRT_WB (no write-back)
- dmem_req  out  1  data-memory request
- mem_fault  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- States: RUN, MEM_WAIT, HALT. Reset state RUN.
- Load-use hazard (lu): id_ex_memread && id_ex_rd≠0 && (id_ex_rd==id_rs1 || id_ex_rd==id_rs2).
- mem_access = ex_mem_memread | ex_mem_memwrite. dmem_req = mem_access in RUN or MEM_WAIT; 0 in HALT.
- RUN, mem_access && !dmem_ready: go MEM_WAIT. Same cycle: pc_en, if_id_en, id_ex_en, ex_mem_en = 0, mem_wb_bubble = 1, no flushes.
- RUN, otherwise (no access, or zero-wait access with dmem_ready):
  - all enables = 1.
  - If ex_branch_taken: if_id_flush = id_ex_flush = 1; lu is ignored.
  - Else if lu: pc_en = if_id_en = 0, id_ex_flush = 1.
- MEM_WAIT, !dmem_ready: freeze as above, wait counter increments.
  - When the counter reaches MEM_TIMEOUT, go HALT and set mem_fault.
- MEM_WAIT, dmem_ready: behave exactly as RUN's non-stall case for this cycle (branch/lu rules apply), return to RUN, clear wait counter.
- HALT: all enables 0, mem_wb_bubble = 1, dmem_req = 0. Exit only by reset.
- Priority: memory stall > branch flush > load-use stall.
  - A branch held during MEM_WAIT stays asserted, since EX is frozen, and is applied on release.
- stall_cnt increments in any cycle with pc_en = 0 outside HALT. Saturates at 2^CNT_W−1, no wrap.

## Timing
- FSM state, wait counter, mem_fault and stall_cnt are registered.
- All enables, flushes, mem_wb_bubble and dmem_req are combinational from state and current inputs: zero-cycle response.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 flushed slots.
- Zero-wait memory access costs 0 cycles. An N-cycle wait costs N stall cycles.
- Timeout: with dmem_ready low from the first request cycle, HALT is entered on the edge ending the MEM_TIMEOUT-th MEM_WAIT cycle.
- While rst is low, regardless of clock:
  - state = RUN, counters = 0, mem_fault = 0.
  - all enables = 0, if_id_flush = id_ex_flush = 1, mem_wb_bubble = 1, dmem_req = 0.
- Reset asserted mid-MEM_WAIT aborts the access immediately: dmem_req drops asynchronously.

## Structure
- Shared package rv32i_pipe_pkg holds:
  - ctrl_state_t enum (RUN, MEM_WAIT, HALT)
  - REG_X0 = 5'd0 constant
  - the CRT_WB zero encoding used for bubbles
- Sub-module hazard_detect: purely combinational lu comparator, reusable by the forwarding unit.

## Test plan
- id_ex_memread=1, id_ex_rd=5, id_rs2=5, no mem access → one cycle: pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0→1. Next cycle enables all 1.
- Same as above but id_ex_rd=0 → no stall.
- ex_branch_taken=1 together with lu → if_id_flush=id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- ex_mem_memread=1, dmem_ready low for 3 cycles then high → 3 cycles with ex_mem_en=0 and mem_wb_bubble=1. Release on the 4th cycle with enables 1, stall_cnt=3.
- MEM_TIMEOUT=4, dmem_ready never high → HALT after 4 wait cycles: mem_fault=1, dmem_req=0, all enables 0. Asserting rst low clears mem_fault and returns to RUN.
- Assert rst low mid-MEM_WAIT → dmem_req=0 and flushes=1 in the same cycle. After release: RUN, stall_cnt=0.

Source files
------------

// File: rtl/rv32i_pipe_pkg.sv
// Types and constants shared by the RV32I pipeline control blocks.
package rv32i_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Write-back control word carried in MEM/WB; all-zero means no write-back.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } crt_wb_t;

    localparam crt_wb_t CRT_WB_NOP = '0;

    function automatic logic is_wb_bubble(input crt_wb_t wb);
        return wb == CRT_WB_NOP;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module hazard_detect
    import rv32i_pipe_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rd,
    output logic       load_use
);

    assign load_use = id_ex_memread && (id_ex_rd != REG_X0) &&
                      ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, branch redirect and
// data-memory wait states, with a memory timeout and a saturating stall counter.
module pipeline_hazard_ctrl
    import rv32i_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mem_memread,
    input  logic             ex_mem_memwrite,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             dmem_req,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_fault_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic load_use;
    logic mem_access;
    logic mem_freeze;

    hazard_detect u_hazard_detect (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_ex_memread (id_ex_memread),
        .id_ex_rd      (id_ex_rd),
        .load_use      (load_use)
    );

    assign mem_access = ex_mem_memread | ex_mem_memwrite;
    // Once waiting, EX/MEM is frozen, so only dmem_ready decides the release.
    assign mem_freeze = (state_reg == MEM_WAIT) ? !dmem_ready
                                                : (mem_access && !dmem_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        case (state_reg)
            RUN: begin
                if (mem_freeze) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next = RUN;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = HALT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        dmem_req      = 1'b0;
        if (!rst) begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (state_reg == HALT) begin
            mem_wb_bubble = 1'b1;
        end else begin
            dmem_req = mem_access;
            if (mem_freeze) begin
                mem_wb_en     = 1'b1;
                mem_wb_bubble = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg  <= '0;
            mem_fault_reg <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (state_reg == MEM_WAIT && state_next == HALT) begin
                mem_fault_reg <= 1'b1;
            end
            if (!pc_en && state_reg != HALT && stall_cnt_reg != '1) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign mem_fault = mem_fault_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule
